pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Drives stall/flush for IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC write-enable/redirect.
//  Resolves data-memory waits, load-use hazards, EX branch mispredicts, ID jumps and fetch waits.
//  Latches a pending redirect target across in-flight fetches and freezes the pipe on halt.
//  Sits beside the datapath; its outputs feed the pipeline registers' flush/stall pins and the PC mux.
// PARAMETERS
//  PC_W   16  PC / target width (WORD_SIZE)
//  CNT_W  16  perf-counter width (used only with HAZARD_PERF_COUNT_EN)
// PORTS
//  clk               in   1     clock, rising edge
//  reset_n           in   1     asynchronous reset, active-low
//  rs_ID, rt_ID      in   2     ID source register addresses
//  use_rs_ID, use_rt_ID in 1    ID instruction actually reads rs / rt
//  d_readM_EX        in   1     EX instruction is a load
//  RegWrite_EX       in   1     EX instruction writes RF
//  write_reg_addr_EX in   2     EX destination register
//  mispredict_EX     in   1     EX branch outcome != branch_predicted_pc_EX
//  correct_pc_EX     in   PC_W  resolved EX branch PC
//  jump_ID           in   1     JMP/JAL/JPR/JRL decoded in ID
//  jump_target_ID    in   PC_W  ID jump target
//  i_mem_busy        in   1     instruction fetch in flight, no valid instruction this cycle
//  d_mem_busy        in   1     data access in MEM not complete
//  is_halted_WB      in   1     HLT reached WB
//  stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB  out 1   hold respective register
//  flush_IF_ID, flush_ID_EX, flush_EX_MEM                out 1   load NOP/zeros into register
//  pc_write          out  1     PC updates this cycle
//  pc_redirect       out  1     PC loads redirect_pc instead of predicted PC (qualified by pc_write)
//  redirect_pc       out  PC_W  redirect target
//  halted            out  1     registered; pipeline frozen after HLT
// BEHAVIOUR
//  Reset (reset_n=0, async): state=RUN, redirect_pc=0, halted=0; all stall/flush=0, pc_write=0, pc_redirect=0.
//  States: RUN, DWAIT, IDRAIN, HALT. Outputs combinational from state+inputs except redirect_pc, halted.
//  RUN priority (first match wins each cycle):
//   1 is_halted_WB: all stall=1, pc_write=0; next HALT, halted<=1.
//   2 d_mem_busy: all four stall=1, pc_write=0, no flush; next DWAIT.
//   3 mispredict_EX: flush_IF_ID=flush_ID_EX=1; target=correct_pc_EX.
//   4 load-use (d_readM_EX & RegWrite_EX & ((use_rs_ID & rs_ID==write_reg_addr_EX) |
//     (use_rt_ID & rt_ID==write_reg_addr_EX))): stall_IF_ID=1, flush_ID_EX=1, pc_write=0; 1-cycle bubble.
//   5 jump_ID: flush_IF_ID=1; target=jump_target_ID.
//   6 i_mem_busy: pc_write=0, flush_IF_ID=1 (bubble into ID), rest flow.
//   7 else pc_write=1, pc_redirect=0.
//   For 3/5: if i_mem_busy=0 -> pc_write=1, pc_redirect=1, redirect_pc drives target combinationally
//   same cycle; else redirect_pc<=target, pc_write=0, next IDRAIN.
//  DWAIT: all stall=1 while d_mem_busy; on d_mem_busy=0 apply RUN priority in the same cycle, next per RUN.
//  IDRAIN: flush_IF_ID=1, pc_write=0, rest flow; redirect_pc held; new mispredict_EX overwrites redirect_pc
//   (mispredict beats jump). On i_mem_busy=0: pc_write=1, pc_redirect=1, next RUN.
//   d_mem_busy in IDRAIN: all stall=1, redirect_pc kept, stay IDRAIN.
//  HALT: all stall=1, flush=0, pc_write=0, halted=1; exits only via reset.
//  Flush beats stall in the registers; the block never asserts stall and flush on the same register.
// CONFIGURATION
//  HAZARD_PERF_COUNT_EN defined: extra outputs stall_cycles[CNT_W] (count cycles with pc_write=0, state!=HALT)
//   and flush_events[CNT_W] (count cycles with flush_IF_ID|flush_ID_EX); both saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Load R1 in EX, ID ADD reads R1 (use_rs_ID=1) -> 1 cycle stall_IF_ID=1, flush_ID_EX=1, pc_write=0; then flows.
//  d_mem_busy high 3 cycles -> all four stall=1 for 3 cycles, no flush, pc_write=1 on 4th.
//  mispredict_EX, correct_pc_EX=16'h0040, i_mem_busy=0 -> same cycle flush_IF_ID/ID_EX=1, pc_redirect=1, redirect_pc=0040.
//  jump_ID target 16'h0100 with i_mem_busy 2 cycles -> IDRAIN, flush_IF_ID=1 x2, then pc_redirect with 0100.
//  IDRAIN for jump 0100, mispredict_EX correct_pc_EX=0020 arrives -> redirect_pc=0020 on release.
//  is_halted_WB=1 -> halted=1 next cycle, all stall=1 until reset_n=0 mid-halt clears to RUN.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stall/flush, PC write-enable and redirect for a 4-stage register chain.
// Optional perf counters are enabled by defining HAZARD_PERF_COUNT_EN.
module pipeline_hazard_controller #(
   parameter int unsigned PC_W  = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      rs_ID,
   input  logic [1:0]      rt_ID,
   input  logic            use_rs_ID,
   input  logic            use_rt_ID,
   input  logic            d_readM_EX,
   input  logic            RegWrite_EX,
   input  logic [1:0]      write_reg_addr_EX,
   input  logic            mispredict_EX,
   input  logic [PC_W-1:0] correct_pc_EX,
   input  logic            jump_ID,
   input  logic [PC_W-1:0] jump_target_ID,
   input  logic            i_mem_busy,
   input  logic            d_mem_busy,
   input  logic            is_halted_WB,
   output logic            stall_IF_ID,
   output logic            stall_ID_EX,
   output logic            stall_EX_MEM,
   output logic            stall_MEM_WB,
   output logic            flush_IF_ID,
   output logic            flush_ID_EX,
   output logic            flush_EX_MEM,
   output logic            pc_write,
   output logic            pc_redirect,
   output logic [PC_W-1:0] redirect_pc,
   output logic            halted
`ifdef HAZARD_PERF_COUNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
`endif
);

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_DWAIT  = 2'd1;
   localparam logic [1:0] S_IDRAIN = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
   logic            halted_q, halted_d;
   logic [PC_W-1:0] target;
   logic            take_redirect;
   logic            redirect_now;
   logic            load_use;

   assign load_use = d_readM_EX & RegWrite_EX &
                     ((use_rs_ID & (rs_ID == write_reg_addr_EX)) |
                      (use_rt_ID & (rt_ID == write_reg_addr_EX)));

   // Next-state and control decode; everything is forced quiet while reset is held
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      halted_d      = halted_q;
      target        = redirect_pc_q;
      take_redirect = 1'b0;
      redirect_now  = 1'b0;
      stall_IF_ID   = 1'b0;
      stall_ID_EX   = 1'b0;
      stall_EX_MEM  = 1'b0;
      stall_MEM_WB  = 1'b0;
      flush_IF_ID   = 1'b0;
      flush_ID_EX   = 1'b0;
      flush_EX_MEM  = 1'b0;
      pc_write      = 1'b0;
      pc_redirect   = 1'b0;
      if (reset_n) begin
         case (state_q)
            S_RUN, S_DWAIT: begin
               if (is_halted_WB) begin
                  {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 4'b1111;
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else if (d_mem_busy) begin
                  {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 4'b1111;
                  state_d = S_DWAIT;
               end else begin
                  state_d = S_RUN;
                  if (mispredict_EX) begin
                     flush_IF_ID   = 1'b1;
                     flush_ID_EX   = 1'b1;
                     target        = correct_pc_EX;
                     take_redirect = 1'b1;
                  end else if (load_use) begin
                     stall_IF_ID = 1'b1;
                     flush_ID_EX = 1'b1;
                  end else if (jump_ID) begin
                     flush_IF_ID   = 1'b1;
                     target        = jump_target_ID;
                     take_redirect = 1'b1;
                  end else if (i_mem_busy) begin
                     flush_IF_ID = 1'b1;
                  end else begin
                     pc_write = 1'b1;
                  end
                  // Redirect now if fetch is idle, otherwise park the target until it drains
                  if (take_redirect) begin
                     redirect_pc_d = target;
                     if (!i_mem_busy) begin
                        pc_write     = 1'b1;
                        pc_redirect  = 1'b1;
                        redirect_now = 1'b1;
                     end else begin
                        state_d = S_IDRAIN;
                     end
                  end
               end
            end
            S_IDRAIN: begin
               if (is_halted_WB) begin
                  {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 4'b1111;
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else if (d_mem_busy) begin
                  {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 4'b1111;
               end else begin
                  flush_IF_ID = 1'b1;
                  if (mispredict_EX) begin
                     flush_ID_EX   = 1'b1;
                     target        = correct_pc_EX;
                     redirect_pc_d = correct_pc_EX;
                  end
                  if (!i_mem_busy) begin
                     pc_write     = 1'b1;
                     pc_redirect  = 1'b1;
                     redirect_now = 1'b1;
                     state_d      = S_RUN;
                  end
               end
            end
            S_HALT: begin
               {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 4'b1111;
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   assign redirect_pc = redirect_now ? target : redirect_pc_q;
   assign halted      = halted_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_RUN;
         redirect_pc_q <= '0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         halted_q      <= halted_d;
      end
   end

`ifdef HAZARD_PERF_COUNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_events_q, flush_events_d;

   // Saturating event counters
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (!pc_write && (state_q != S_HALT) && (stall_cycles_q != {CNT_W{1'b1}}))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if ((flush_IF_ID || flush_ID_EX) && (flush_events_q != {CNT_W{1'b1}}))
         flush_events_d = flush_events_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: per-cycle model compare plus directed literal checks.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_HALT  = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  rs_ID, rt_ID, write_reg_addr_EX;
   logic        use_rs_ID, use_rt_ID, d_readM_EX, RegWrite_EX;
   logic        mispredict_EX, jump_ID, i_mem_busy, d_mem_busy, is_halted_WB;
   logic [15:0] correct_pc_EX, jump_target_ID;
   logic        stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
   logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_write, pc_redirect, halted;
   logic [15:0] redirect_pc;
`ifdef HAZARD_PERF_COUNT_EN
   logic [15:0] stall_cycles, flush_events;
`endif

   int n_chk = 0;
   int n_pass = 0;

   pipeline_hazard_controller dut (
      .clk(clk), .reset_n(reset_n),
      .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
      .d_readM_EX(d_readM_EX), .RegWrite_EX(RegWrite_EX), .write_reg_addr_EX(write_reg_addr_EX),
      .mispredict_EX(mispredict_EX), .correct_pc_EX(correct_pc_EX),
      .jump_ID(jump_ID), .jump_target_ID(jump_target_ID),
      .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy), .is_halted_WB(is_halted_WB),
      .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
      .stall_MEM_WB(stall_MEM_WB), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
      .flush_EX_MEM(flush_EX_MEM), .pc_write(pc_write), .pc_redirect(pc_redirect),
      .redirect_pc(redirect_pc), .halted(halted)
`ifdef HAZARD_PERF_COUNT_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   always #5 clk = ~clk;

   // {stall IF_ID, ID_EX, EX_MEM, MEM_WB, flush IF_ID, ID_EX, EX_MEM, pc_write, pc_redirect}
   wire [8:0] bund = {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                      flush_IF_ID, flush_ID_EX, flush_EX_MEM, pc_write, pc_redirect};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      else n_pass++;
   endtask

   // Behavioural model: pipeline mode, parked target, halted flag
   int          m_mode = M_RUN, n_mode = M_RUN;
   logic [15:0] m_tgt = '0, n_tgt = '0;
   logic        m_halted = 1'b0, n_halted = 1'b0;
   logic [8:0]  e_b;
   logic [15:0] e_pc;
   logic        e_h, lu, redir;

   always @(negedge clk) begin
      e_b = '0; e_pc = m_tgt; e_h = m_halted;
      n_mode = m_mode; n_tgt = m_tgt; n_halted = m_halted;
      lu = d_readM_EX && RegWrite_EX &&
           ((use_rs_ID && rs_ID == write_reg_addr_EX) || (use_rt_ID && rt_ID == write_reg_addr_EX));
      redir = 1'b0;
      if (!reset_n) begin
         e_pc = '0; e_h = 1'b0;
      end else if (m_mode == M_HALT || is_halted_WB) begin
         e_b = 9'b111100000; n_mode = M_HALT; n_halted = 1'b1;
      end else if (d_mem_busy) begin
         e_b = 9'b111100000;
      end else if (m_mode == M_DRAIN) begin
         e_b[4] = 1'b1;
         if (mispredict_EX) begin e_b[3] = 1'b1; n_tgt = correct_pc_EX; end
         if (!i_mem_busy) begin e_b[1:0] = 2'b11; e_pc = n_tgt; n_mode = M_RUN; end
      end else begin
         if (mispredict_EX) begin e_b[4] = 1'b1; e_b[3] = 1'b1; n_tgt = correct_pc_EX; redir = 1'b1; end
         else if (lu) begin e_b[8] = 1'b1; e_b[3] = 1'b1; end
         else if (jump_ID) begin e_b[4] = 1'b1; n_tgt = jump_target_ID; redir = 1'b1; end
         else if (i_mem_busy) e_b[4] = 1'b1;
         else e_b[1] = 1'b1;
         if (redir) begin
            if (!i_mem_busy) begin e_b[1:0] = 2'b11; e_pc = n_tgt; end
            else n_mode = M_DRAIN;
         end
      end
      chk("model_ctl", 32'(bund), 32'(e_b));
      if (e_b[0] || !reset_n) chk("model_rpc", 32'(redirect_pc), 32'(e_pc));
      chk("model_halted", 32'(halted), 32'(e_h));
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode <= M_RUN; m_tgt <= '0; m_halted <= 1'b0;
      end else begin
         m_mode <= n_mode; m_tgt <= n_tgt; m_halted <= n_halted;
      end
   end

   task automatic clr();
      rs_ID = '0; rt_ID = '0; write_reg_addr_EX = '0; use_rs_ID = 0; use_rt_ID = 0;
      d_readM_EX = 0; RegWrite_EX = 0; mispredict_EX = 0; jump_ID = 0; i_mem_busy = 0;
      d_mem_busy = 0; is_halted_WB = 0; correct_pc_EX = '0; jump_target_ID = '0;
   endtask

   task automatic fin();
      @(posedge clk); #1;
   endtask

   task automatic step_lit(input string nm, input logic [8:0] eb);
      @(negedge clk); chk(nm, 32'(bund), 32'(eb)); fin();
   endtask

   initial begin
      clr();
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("rst_ctl", 32'(bund), 32'd0);
      chk("rst_rpc", 32'(redirect_pc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      fin(); reset_n = 1'b1;

      step_lit("idle", 9'b000000010);
      d_readM_EX = 1; RegWrite_EX = 1; write_reg_addr_EX = 2'd1; rs_ID = 2'd1; use_rs_ID = 1;
      step_lit("loaduse_rs", 9'b100001000);
      clr(); step_lit("after_loaduse", 9'b000000010);
      d_readM_EX = 1; RegWrite_EX = 1; write_reg_addr_EX = 2'd2; rt_ID = 2'd2; use_rt_ID = 1; rs_ID = 2'd2;
      step_lit("loaduse_rt", 9'b100001000);
      clr(); d_readM_EX = 1; RegWrite_EX = 1; write_reg_addr_EX = 2'd3; rs_ID = 2'd3;
      step_lit("loaduse_unused_src", 9'b000000010);
      clr(); RegWrite_EX = 1; write_reg_addr_EX = 2'd1; rs_ID = 2'd1; use_rs_ID = 1;
      step_lit("no_load_no_stall", 9'b000000010);

      clr(); d_mem_busy = 1;
      repeat (3) step_lit("dmem_wait", 9'b111100000);
      d_mem_busy = 0; step_lit("dmem_release", 9'b000000010);

      mispredict_EX = 1; correct_pc_EX = 16'h0040;
      @(negedge clk); chk("mispred_ctl", 32'(bund), 32'(9'b000011011));
      chk("mispred_rpc", 32'(redirect_pc), 32'h0040); fin();
      clr(); step_lit("after_mispred", 9'b000000010);

      jump_ID = 1; jump_target_ID = 16'h0100; i_mem_busy = 1;
      step_lit("jump_busy", 9'b000010000);
      jump_ID = 0;
      @(negedge clk); chk("idrain_ctl", 32'(bund), 32'(9'b000010000));
      chk("idrain_rpc", 32'(redirect_pc), 32'h0100); fin();
      i_mem_busy = 0;
      @(negedge clk); chk("jump_release", 32'(bund), 32'(9'b000010011));
      chk("jump_release_rpc", 32'(redirect_pc), 32'h0100); fin();
      clr(); step_lit("after_jump", 9'b000000010);

      jump_ID = 1; jump_target_ID = 16'h0100; i_mem_busy = 1; fin();
      jump_ID = 0; mispredict_EX = 1; correct_pc_EX = 16'h0020;
      step_lit("idrain_mispred", 9'b000011000);
      mispredict_EX = 0; i_mem_busy = 0;
      @(negedge clk); chk("overwrite_ctl", 32'(bund), 32'(9'b000010011));
      chk("overwrite_rpc", 32'(redirect_pc), 32'h0020); fin();

      clr(); jump_ID = 1; jump_target_ID = 16'h0200; i_mem_busy = 1; fin();
      jump_ID = 0; i_mem_busy = 0; mispredict_EX = 1; correct_pc_EX = 16'h0300;
      @(negedge clk); chk("release_mispred_ctl", 32'(bund), 32'(9'b000011011));
      chk("release_mispred_rpc", 32'(redirect_pc), 32'h0300); fin();

      clr(); jump_ID = 1; jump_target_ID = 16'h0400; i_mem_busy = 1; fin();
      jump_ID = 0; d_mem_busy = 1;
      repeat (2) step_lit("idrain_dmem", 9'b111100000);
      d_mem_busy = 0; i_mem_busy = 0;
      @(negedge clk); chk("idrain_dmem_rel", 32'(bund), 32'(9'b000010011));
      chk("idrain_dmem_rpc", 32'(redirect_pc), 32'h0400); fin();

      clr(); mispredict_EX = 1; correct_pc_EX = 16'h0080;
      d_readM_EX = 1; RegWrite_EX = 1; write_reg_addr_EX = 2'd1; rs_ID = 2'd1; use_rs_ID = 1;
      step_lit("mispred_over_loaduse", 9'b000011011);
      clr(); i_mem_busy = 1; step_lit("fetch_bubble", 9'b000010000);
      clr(); jump_ID = 1; jump_target_ID = 16'h0600; d_mem_busy = 1;
      step_lit("dmem_over_jump", 9'b111100000);

      clr(); is_halted_WB = 1; d_mem_busy = 1;
      @(negedge clk); chk("halt_ctl", 32'(bund), 32'(9'b111100000));
      chk("halt_flag_lag", 32'(halted), 32'd0); fin();
      clr(); mispredict_EX = 1; correct_pc_EX = 16'h0055;
      @(negedge clk); chk("halt_hold", 32'(bund), 32'(9'b111100000));
      chk("halt_flag", 32'(halted), 32'd1); fin();
      repeat (2) step_lit("halt_frozen", 9'b111100000);
      reset_n = 1'b0;
      @(negedge clk); chk("halt_reset_ctl", 32'(bund), 32'd0);
      chk("halt_reset_flag", 32'(halted), 32'd0); fin();
      reset_n = 1'b1; clr();
      step_lit("post_reset_run", 9'b000000010);
      fin();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
